// File: rtl/alu_pkg.sv
// Shared constants and FIFO entry type for the ALU issue stage.
package alu_pkg;

   localparam logic [3:0] ALU_ADD  = 4'h0;
   localparam logic [3:0] ALU_AND  = 4'h1;
   localparam logic [3:0] ALU_OR   = 4'h2;
   localparam logic [3:0] ALU_XOR  = 4'h3;
   localparam logic [3:0] ALU_SUB  = 4'h4;
   localparam logic [3:0] ALU_SLT  = 4'h5;
   localparam logic [3:0] ALU_SLTU = 4'h6;
   localparam logic [3:0] ALU_SLL  = 4'h7;
   localparam logic [3:0] ALU_SRL  = 4'h8;
   localparam logic [3:0] ALU_SRA  = 4'h9;
   localparam logic [3:0] ALU_LUI  = 4'hA;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      logic [31:0] in1;
      logic [31:0] in2;
      logic [3:0]  op;
      logic [4:0]  rd;
      logic        illegal;
   } alu_entry_t;

   // alt selects SUB for funct3 000 and SRA for funct3 101; ignored otherwise
   function automatic logic [3:0] f3_to_op(input logic [2:0] f3, input logic alt);
      logic [3:0] op;
      case (f3)
         F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
         F3_SLL:  op = ALU_SLL;
         F3_SLT:  op = ALU_SLT;
         F3_SLTU: op = ALU_SLTU;
         F3_XOR:  op = ALU_XOR;
         F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
         F3_OR:   op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/alu_issue_dec.sv
// Combinational RV32I integer-ALU decoder: instruction plus operands to ALU op and inputs.
module alu_issue_dec
   import alu_pkg::*;
(
   input  logic [31:0] instr,
   input  logic [31:0] pc,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   output logic [31:0] in1,
   output logic [31:0] in2,
   output logic [3:0]  op,
   output logic [4:0]  rd,
   output logic        illegal
);

   logic [6:0]  opcode;
   logic [6:0]  funct7;
   logic [2:0]  funct3;
   logic [31:0] imm_i;
   logic [31:0] imm_u;
   logic [31:0] shamt;
   logic        is_shift;

   assign opcode   = instr[6:0];
   assign funct3   = instr[14:12];
   assign funct7   = instr[31:25];
   assign imm_i    = {{20{instr[31]}}, instr[31:20]};
   assign imm_u    = {instr[31:12], 12'b0};
   assign shamt    = {27'b0, instr[24:20]};
   assign is_shift = (funct3 == F3_SLL) || (funct3 == F3_SR);

   always_comb begin
      in1     = '0;
      in2     = '0;
      op      = ALU_ADD;
      illegal = 1'b0;
      case (opcode)
         OPC_OP: begin
            if (funct7 == F7_BASE || funct7 == F7_ALT) begin
               in1 = rs1;
               in2 = rs2;
               op  = f3_to_op(funct3, funct7 == F7_ALT);
            end else begin
               illegal = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            in1 = rs1;
            in2 = is_shift ? shamt : imm_i;
            // ADDI has no subtract form, so instr[30] only matters for right shifts
            op  = f3_to_op(funct3, instr[30] && (funct3 == F3_SR));
         end
         OPC_LUI: begin
            in2 = imm_u;
            op  = ALU_LUI;
         end
         OPC_AUIPC: begin
            in1 = pc;
            in2 = imm_u;
         end
         default: illegal = 1'b1;
      endcase
      rd = illegal ? 5'd0 : instr[11:7];
   end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes accepted instructions into a DEPTH-entry output FIFO.
// Optional ALU_ISSUE_ILLEGAL_EN adds out_illegal and a saturating illegal_cnt.
module alu_issue
   import alu_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_rs1,
   input  logic [31:0] in_rs2,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_in1,
   output logic [31:0] out_in2,
   output logic [3:0]  out_op,
   output logic [4:0]  out_rd
`ifdef ALU_ISSUE_ILLEGAL_EN
   ,
   output logic        out_illegal,
   output logic [7:0]  illegal_cnt
`endif
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   alu_entry_t       dec_entry;
   alu_entry_t       mem [DEPTH];
   alu_entry_t       head;
   alu_entry_t       hold_q;
   alu_entry_t       shown;
   logic [PTR_W-1:0] wr_q;
   logic [PTR_W-1:0] rd_q;
   logic [CNT_W-1:0] cnt_q;
   logic             push;
   logic             pop;

   alu_issue_dec u_dec (
      .instr   (in_instr),
      .pc      (in_pc),
      .rs1     (in_rs1),
      .rs2     (in_rs2),
      .in1     (dec_entry.in1),
      .in2     (dec_entry.in2),
      .op      (dec_entry.op),
      .rd      (dec_entry.rd),
      .illegal (dec_entry.illegal)
   );

   // A full FIFO refuses pushes even when a pop happens in the same cycle
   assign in_ready  = cnt_q < CNT_W'(DEPTH);
   assign out_valid = cnt_q != '0;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign head      = mem[rd_q];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_q] <= dec_entry;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q   <= '0;
         rd_q   <= '0;
         cnt_q  <= '0;
         hold_q <= '0;
      end else begin
         if (push) begin
            wr_q <= wr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_q   <= rd_q + PTR_W'(1);
            hold_q <= head;
         end
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: ;
         endcase
      end
   end

   // Empty FIFO shows the last popped entry, which reset clears to zero
   assign shown   = out_valid ? head : hold_q;
   assign out_in1 = shown.in1;
   assign out_in2 = shown.in2;
   assign out_op  = shown.op;
   assign out_rd  = shown.rd;

`ifdef ALU_ISSUE_ILLEGAL_EN
   logic [7:0] ill_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ill_cnt_q <= '0;
      end else if (push && dec_entry.illegal && ill_cnt_q != 8'hFF) begin
         ill_cnt_q <= ill_cnt_q + 8'd1;
      end
   end

   assign out_illegal = shown.illegal;
   assign illegal_cnt = ill_cnt_q;
`else
   logic unused_illegal;
   assign unused_illegal = shown.illegal;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue; define ALU_ISSUE_ILLEGAL_EN to also check illegal reporting.
`timescale 1ns/1ps
module tb_alu_issue;
   import alu_pkg::*;

   localparam int unsigned DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic [31:0] in_rs1;
   logic [31:0] in_rs2;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_in1;
   logic [31:0] out_in2;
   logic [3:0]  out_op;
   logic [4:0]  out_rd;
`ifdef ALU_ISSUE_ILLEGAL_EN
   logic        out_illegal;
   logic [7:0]  illegal_cnt;
`endif

   always #5 clk = ~clk;

   alu_issue #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .in_pc       (in_pc),
      .in_rs1      (in_rs1),
      .in_rs2      (in_rs2),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_in1     (out_in1),
      .out_in2     (out_in2),
      .out_op      (out_op),
      .out_rd      (out_rd)
`ifdef ALU_ISSUE_ILLEGAL_EN
      ,
      .out_illegal (out_illegal),
      .illegal_cnt (illegal_cnt)
`endif
   );

   alu_entry_t sb[$];
   int n_cmp = 0;
   int n_err = 0;

   function automatic alu_entry_t mk(input logic [31:0] in1, input logic [31:0] in2,
                                     input logic [3:0] op, input logic [4:0] rd,
                                     input logic ill);
      alu_entry_t e;
      e.in1 = in1;
      e.in2 = in2;
      e.op  = op;
      e.rd  = rd;
`ifdef ALU_ISSUE_ILLEGAL_EN
      e.illegal = ill;
`else
      e.illegal = 1'b0 & ill;
`endif
      return e;
   endfunction

   function automatic alu_entry_t observe();
      alu_entry_t e;
      e.in1 = out_in1;
      e.in2 = out_in2;
      e.op  = out_op;
      e.rd  = out_rd;
`ifdef ALU_ISSUE_ILLEGAL_EN
      e.illegal = out_illegal;
`else
      e.illegal = 1'b0;
`endif
      return e;
   endfunction

   function automatic alu_entry_t sb_pop();
      if (sb.size() == 0) return '0;
      return sb.pop_front();
   endfunction

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic offer(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2,
                        input alu_entry_t exp, output bit acc);
      in_valid = 1'b1;
      in_instr = instr;
      in_pc    = pc;
      in_rs1   = rs1;
      in_rs2   = rs2;
      acc      = 1'b0;
      for (int i = 0; i < 20 && !acc; i++) begin
         #1;
         if (in_ready) begin
            sb.push_back(exp);
            acc = 1'b1;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic take(output bit got, output alu_entry_t obs);
      got       = 1'b0;
      obs       = '0;
      out_ready = 1'b1;
      for (int i = 0; i < 20 && !got; i++) begin
         #1;
         if (out_valid) begin
            obs = observe();
            got = 1'b1;
         end
         @(negedge clk);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = '0; in_pc = '0; in_rs1 = '0; in_rs2 = '0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_hs: valid=%b ready=%b want 0/1", out_valid, in_ready);
      end
      n_cmp++;
      if (observe() !== alu_entry_t'(0)) begin
         n_err++;
         $display("FAIL reset_out: got %h want 0", observe());
      end
`ifdef ALU_ISSUE_ILLEGAL_EN
      n_cmp++;
      if (illegal_cnt !== 8'd0) begin
         n_err++;
         $display("FAIL reset_cnt: got %0d want 0", illegal_cnt);
      end
`endif
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_add();
      bit acc, got;
      alu_entry_t obs, exp;
      offer(32'h00208033, 32'h0, 32'd5, 32'd7, mk(32'd5, 32'd7, ALU_ADD, 5'd0, 1'b0), acc);
      #1;
      n_cmp++;
      if (!acc || out_valid !== 1'b1) begin
         n_err++;
         $display("FAIL add_latency: acc=%b valid=%b want 1/1", acc, out_valid);
      end
      take(got, obs);
      exp = sb_pop();
      n_cmp++;
      if (!got || obs !== exp) begin
         n_err++;
         $display("FAIL add: got %h want %h", obs, exp);
      end
   endtask

   task automatic test_illegal();
      bit acc, got;
      alu_entry_t obs, exp;
      offer(32'h0000007F, 32'h40, 32'h1234, 32'h5678, mk(32'd0, 32'd0, ALU_ADD, 5'd0, 1'b1), acc);
      take(got, obs);
      exp = sb_pop();
      n_cmp++;
      if (!acc || !got || obs !== exp) begin
         n_err++;
         $display("FAIL illegal_op: got %h want %h", obs, exp);
      end
`ifdef ALU_ISSUE_ILLEGAL_EN
      n_cmp++;
      if (illegal_cnt !== 8'd1) begin
         n_err++;
         $display("FAIL illegal_cnt1: got %0d want 1", illegal_cnt);
      end
      begin
         int n_acc = 0;
         out_ready = 1'b1;
         in_valid  = 1'b1;
         in_instr  = 32'h0000007F;
         for (int i = 0; i < 600 && n_acc < 255; i++) begin
            #1;
            if (in_ready) n_acc++;
            @(negedge clk);
         end
         in_valid = 1'b0;
         repeat (3) @(negedge clk);
         out_ready = 1'b0;
         n_cmp++;
         if (n_acc != 255 || illegal_cnt !== 8'd255) begin
            n_err++;
            $display("FAIL illegal_sat: accepted=%0d cnt=%0d want 255/255", n_acc, illegal_cnt);
         end
      end
      offer(32'h0000007F, 32'h0, 32'h0, 32'h0, mk(32'd0, 32'd0, ALU_ADD, 5'd0, 1'b1), acc);
      take(got, obs);
      void'(sb_pop());
      n_cmp++;
      if (illegal_cnt !== 8'd255) begin
         n_err++;
         $display("FAIL illegal_hold: got %0d want 255", illegal_cnt);
      end
`endif
   endtask

   task automatic test_decode();
      logic [31:0] t_instr [8] = '{32'h4030D093, 32'h402081B3, 32'hFFF08113, 32'h0020B1B3,
                                   32'h7F00C293, 32'h022082B3, 32'h4020D333, 32'h01F09393};
      logic [31:0] t_rs1 [8] = '{32'h80000000, 32'd10, 32'd9, 32'd1,
                                 32'h55, 32'd3, 32'hF0000000, 32'd1};
      logic [31:0] t_rs2 [8] = '{32'hDEADBEEF, 32'd3, 32'd8, 32'd2,
                                 32'd8, 32'd4, 32'd4, 32'd6};
      alu_entry_t t_exp [8];
      bit acc, got;
      alu_entry_t obs, exp;
      t_exp[0] = mk(32'h80000000, 32'd3, ALU_SRA, 5'd1, 1'b0);
      t_exp[1] = mk(32'd10, 32'd3, ALU_SUB, 5'd3, 1'b0);
      t_exp[2] = mk(32'd9, 32'hFFFFFFFF, ALU_ADD, 5'd2, 1'b0);
      t_exp[3] = mk(32'd1, 32'd2, ALU_SLTU, 5'd3, 1'b0);
      t_exp[4] = mk(32'h55, 32'h7F0, ALU_XOR, 5'd5, 1'b0);
      t_exp[5] = mk(32'd0, 32'd0, ALU_ADD, 5'd0, 1'b1);
      t_exp[6] = mk(32'hF0000000, 32'd4, ALU_SRA, 5'd6, 1'b0);
      t_exp[7] = mk(32'd1, 32'd31, ALU_SLL, 5'd7, 1'b0);
      for (int i = 0; i < 8; i++) begin
         offer(t_instr[i], 32'h0, t_rs1[i], t_rs2[i], t_exp[i], acc);
         take(got, obs);
         exp = sb_pop();
         n_cmp++;
         if (!acc || !got || obs !== exp) begin
            n_err++;
            $display("FAIL decode_%0d: instr=%h got %h want %h", i, t_instr[i], obs, exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      bit acc0, acc1, got;
      alu_entry_t obs, exp;
      offer(32'h123451B7, 32'h100, 32'hAAAA, 32'hBBBB,
            mk(32'd0, 32'h12345000, ALU_LUI, 5'd3, 1'b0), acc0);
      offer(32'h00001217, 32'h100, 32'hAAAA, 32'hBBBB,
            mk(32'h100, 32'h1000, ALU_ADD, 5'd4, 1'b0), acc1);
      for (int i = 0; i < 2; i++) begin
         take(got, obs);
         exp = sb_pop();
         n_cmp++;
         if (!acc0 || !acc1 || !got || obs !== exp) begin
            n_err++;
            $display("FAIL b2b_%0d: got %h want %h", i, obs, exp);
         end
      end
   endtask

   task automatic test_backpressure();
      bit acc_a, acc_b;
      alu_entry_t obs [3];
      alu_entry_t exp;
      alu_entry_t exp_c;
      bit r_full, r_full_pop, r_after;
      exp_c = mk(32'd33, 32'd44, ALU_OR, 5'd12, 1'b0);
      out_ready = 1'b0;
      offer(32'h00208533, 32'h0, 32'd11, 32'd22, mk(32'd11, 32'd22, ALU_ADD, 5'd10, 1'b0), acc_a);
      offer(32'h0020F5B3, 32'h0, 32'd1, 32'd2, mk(32'd1, 32'd2, ALU_AND, 5'd11, 1'b0), acc_b);
      in_valid = 1'b1; in_instr = 32'h0020E633; in_rs1 = 32'd33; in_rs2 = 32'd44;
      #1 r_full = in_ready;
      @(negedge clk);
      out_ready = 1'b1;
      #1 r_full_pop = in_ready;
      obs[0] = observe();
      @(negedge clk);
      #1 r_after = in_ready;
      if (r_after) sb.push_back(exp_c);
      obs[1] = observe();
      @(negedge clk);
      in_valid = 1'b0;
      #1 obs[2] = observe();
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      n_cmp++;
      if (!acc_a || !acc_b || r_full !== 1'b0 || r_full_pop !== 1'b0 || r_after !== 1'b1) begin
         n_err++;
         $display("FAIL bp_ready: full=%b full_pop=%b after=%b want 0/0/1",
                  r_full, r_full_pop, r_after);
      end
      for (int i = 0; i < 3; i++) begin
         exp = sb_pop();
         n_cmp++;
         if (obs[i] !== exp) begin
            n_err++;
            $display("FAIL bp_order_%0d: got %h want %h", i, obs[i], exp);
         end
      end
      n_cmp++;
      if (out_valid !== 1'b0 || observe() !== exp_c) begin
         n_err++;
         $display("FAIL bp_hold: valid=%b out=%h want 0/%h", out_valid, observe(), exp_c);
      end
      @(negedge clk);
   endtask

   task automatic test_mid_reset();
      bit acc, got, stale;
      alu_entry_t obs, exp;
      out_ready = 1'b0;
      offer(32'h00208033, 32'h0, 32'd1, 32'd1, mk(32'd1, 32'd1, ALU_ADD, 5'd0, 1'b0), acc);
      offer(32'h00208033, 32'h0, 32'd2, 32'd2, mk(32'd2, 32'd2, ALU_ADD, 5'd0, 1'b0), acc);
      rst = 1'b1;
      #1;
      sb.delete();
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || observe() !== alu_entry_t'(0)) begin
         n_err++;
         $display("FAIL mid_reset: valid=%b ready=%b out=%h want 0/1/0",
                  out_valid, in_ready, observe());
      end
      @(negedge clk);
      rst       = 1'b0;
      out_ready = 1'b1;
      stale     = 1'b0;
      repeat (4) begin
         #1 if (out_valid) stale = 1'b1;
         @(negedge clk);
      end
      out_ready = 1'b0;
      n_cmp++;
      if (stale) begin
         n_err++;
         $display("FAIL mid_reset_stale: got valid=1 want 0");
      end
      offer(32'h0020C033, 32'h0, 32'h77, 32'h0F, mk(32'h77, 32'h0F, ALU_XOR, 5'd0, 1'b0), acc);
      take(got, obs);
      exp = sb_pop();
      n_cmp++;
      if (!acc || !got || obs !== exp || sb.size() != 0) begin
         n_err++;
         $display("FAIL mid_reset_fresh: got %h want %h", obs, exp);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_illegal();
      test_decode();
      test_back_to_back();
      test_backpressure();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
